// File: rtl/dtack_wait_state_generator.sv
// dtack_wait_state_generator
// Generates the 68k DTACK and BERR responses from decoded channel selects.
// Each channel acknowledges in one of two ways:
//   - after a programmable number of wait states, or
//   - by passing through its device's own DTACK.
// A watchdog raises BERR when a selected device never acknowledges.
// All outputs are registered and are driven from the next-state value.
module dtack_wait_state_generator #(
    parameter int NUM_CH         = 4,
    parameter int WS_WIDTH       = 4,
    parameter int TO_WIDTH       = 8,
    parameter int TIMEOUT_CYCLES = 200
) (
    input  logic                         Clk,
    input  logic                         Reset_H,
    input  logic                         AS_L,
    input  logic [NUM_CH-1:0]            Select_H,
    input  logic [NUM_CH-1:0]            ExtMode_H,
    input  logic [NUM_CH-1:0]            ExtDtack_L,
    input  logic [NUM_CH*WS_WIDTH-1:0]   WaitStates,
    input  logic                         ClearFlag_H,
    output logic                         DtackOut_L,
    output logic                         BErrOut_L,
    output logic                         Busy_H,
    output logic                         TimeoutFlag_H,
    output logic [NUM_CH-1:0]            TimeoutChan_H
);

    typedef enum logic [2:0] {
        S_ARM,
        S_IDLE,
        S_WAIT,
        S_ACK,
        S_BERR
    } state_t;

    // Timeout fires on the edge where the counter, cleared at cycle start,
    // has counted TIMEOUT_CYCLES-1 WAIT edges. A value of 0 disables it.
    localparam logic [TO_WIDTH-1:0] TO_LAST = TO_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic                TO_EN   = (TIMEOUT_CYCLES != 0);

    state_t                r_state;
    state_t                w_next;

    logic [NUM_CH-1:0]     r_ch_oh;     // latched channel, all 0 = default region
    logic                  r_ext_mode;
    logic [WS_WIDTH-1:0]   r_ws;
    logic [WS_WIDTH-1:0]   r_ws_cnt;
    logic [TO_WIDTH-1:0]   r_to_cnt;
    logic [NUM_CH-1:0]     r_ext_q;     // device DTACKs as sampled on the previous edge

    logic [NUM_CH-1:0]     w_sel_oh;
    logic                  w_sel_ext;
    logic [WS_WIDTH-1:0]   w_sel_ws;
    logic                  w_start;
    logic                  w_ack;
    logic                  w_timeout;
    logic                  w_to_fire;

    // Lowest-index select wins; pick up its mode and wait-state count
    always_comb begin
        w_sel_oh  = Select_H & (~Select_H + NUM_CH'(1));
        w_sel_ext = |(w_sel_oh & ExtMode_H);
        w_sel_ws  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_sel_oh[i])
                w_sel_ws = WaitStates[i*WS_WIDTH +: WS_WIDTH];
        end
    end

    // Acknowledge and timeout conditions evaluated while waiting
    always_comb begin
        w_start   = (r_state == S_IDLE) && !AS_L;
        if (r_ext_mode)
            w_ack = |(r_ch_oh & ~r_ext_q);
        else
            w_ack = (r_ws_cnt == r_ws);
        w_timeout = TO_EN && (r_to_cnt == TO_LAST);
    end

    // Next-state logic; abort beats ack, and ack beats timeout
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_ARM:  if (AS_L)    w_next = S_IDLE;
            S_IDLE: if (!AS_L)   w_next = S_WAIT;
            S_WAIT: begin
                if (AS_L)           w_next = S_IDLE;
                else if (w_ack)     w_next = S_ACK;
                else if (w_timeout) w_next = S_BERR;
            end
            S_ACK:  if (AS_L)    w_next = S_IDLE;
            S_BERR: if (AS_L)    w_next = S_IDLE;
            default:             w_next = S_ARM;
        endcase
        w_to_fire = (r_state == S_WAIT) && (w_next == S_BERR);
    end

    // State register and Moore outputs registered from the next state
    always_ff @(posedge Clk) begin
        if (Reset_H) begin
            r_state    <= S_ARM;
            DtackOut_L <= 1'b1;
            BErrOut_L  <= 1'b1;
            Busy_H     <= 1'b0;
        end else begin
            r_state    <= w_next;
            DtackOut_L <= (w_next != S_ACK);
            BErrOut_L  <= (w_next != S_BERR);
            Busy_H     <= (w_next == S_WAIT) || (w_next == S_ACK) || (w_next == S_BERR);
        end
    end

    // Per-cycle latches and saturating wait/timeout counters
    always_ff @(posedge Clk) begin
        if (Reset_H) begin
            r_ch_oh    <= '0;
            r_ext_mode <= 1'b0;
            r_ws       <= '0;
            r_ws_cnt   <= '0;
            r_to_cnt   <= '0;
            r_ext_q    <= '1;
        end else begin
            r_ext_q <= ExtDtack_L;
            if (w_start) begin
                r_ch_oh    <= w_sel_oh;
                r_ext_mode <= w_sel_ext;
                r_ws       <= w_sel_ws;
                r_ws_cnt   <= '0;
                r_to_cnt   <= '0;
            end else if (r_state == S_WAIT) begin
                if (r_ws_cnt != '1) r_ws_cnt <= r_ws_cnt + WS_WIDTH'(1);
                if (r_to_cnt != '1) r_to_cnt <= r_to_cnt + TO_WIDTH'(1);
            end
        end
    end

    // Sticky timeout status; a new timeout overrides a same-edge clear
    always_ff @(posedge Clk) begin
        if (Reset_H) begin
            TimeoutFlag_H <= 1'b0;
            TimeoutChan_H <= '0;
        end else if (w_to_fire) begin
            TimeoutFlag_H <= 1'b1;
            TimeoutChan_H <= r_ch_oh;
        end else if (ClearFlag_H) begin
            TimeoutFlag_H <= 1'b0;
            TimeoutChan_H <= '0;
        end
    end

endmodule

// File: tb/tb_dtack_wait_state_generator.sv
// Scoreboard bench for dtack_wait_state_generator.
// A reference model tracks each bus cycle by its start edge. From that edge
// it computes the ack and timeout edges directly. On every rising edge it
// queues the expected outputs, and a monitor compares them on the falling edge.
module tb_dtack_wait_state_generator;

    localparam int NUM_CH = 4;
    localparam int WS_W   = 4;
    localparam int TO_W   = 8;
    localparam int TMO    = 200;

    logic                     Clk = 1'b0;
    logic                     Reset_H = 1'b1;
    logic                     AS_L = 1'b0;
    logic [NUM_CH-1:0]        Select_H = '0;
    logic [NUM_CH-1:0]        ExtMode_H = '0;
    logic [NUM_CH-1:0]        ExtDtack_L = '1;
    logic [NUM_CH*WS_W-1:0]   WaitStates = '0;
    logic                     ClearFlag_H = 1'b0;
    logic                     DtackOut_L, BErrOut_L, Busy_H, TimeoutFlag_H;
    logic [NUM_CH-1:0]        TimeoutChan_H;

    dtack_wait_state_generator #(
        .NUM_CH(NUM_CH), .WS_WIDTH(WS_W), .TO_WIDTH(TO_W), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .Clk(Clk), .Reset_H(Reset_H), .AS_L(AS_L), .Select_H(Select_H),
        .ExtMode_H(ExtMode_H), .ExtDtack_L(ExtDtack_L), .WaitStates(WaitStates),
        .ClearFlag_H(ClearFlag_H), .DtackOut_L(DtackOut_L), .BErrOut_L(BErrOut_L),
        .Busy_H(Busy_H), .TimeoutFlag_H(TimeoutFlag_H), .TimeoutChan_H(TimeoutChan_H)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        int             edge_no;
        logic           dtack_l;
        logic           berr_l;
        logic           busy;
        logic           flag;
        logic [NUM_CH-1:0] chan;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // ---------------- reference model ----------------
    // phase: 0 armed, 1 idle, 2 cycle active, 3 acknowledged, 4 bus error
    initial begin : model
        int e, phase, start, ack_at, ch;
        bit ext, fired;
        logic [NUM_CH-1:0] prev_ext, chan, ch_oh;
        logic flag;
        exp_t x;
        e = 0; phase = 0; start = 0; ack_at = 0; ch = -1; ext = 0;
        prev_ext = '1; chan = '0; flag = 0; ch_oh = '0;
        forever begin
            @(posedge Clk);
            e++;
            fired = 0;
            if (Reset_H) begin
                phase = 0; flag = 0; chan = '0; prev_ext = '1;
            end else begin
                case (phase)
                    0: if (AS_L) phase = 1;
                    1: if (!AS_L) begin
                        ch = -1;
                        for (int i = NUM_CH-1; i >= 0; i--) if (Select_H[i]) ch = i;
                        ch_oh  = (ch < 0) ? '0 : NUM_CH'(1) << ch;
                        ext    = (ch >= 0) && ExtMode_H[ch];
                        ack_at = (ch < 0) ? e + 1 : e + 1 + int'(WaitStates[ch*WS_W +: WS_W]);
                        start  = e;
                        phase  = 2;
                    end
                    2: begin
                        if (AS_L) phase = 1;
                        else if (ext ? (prev_ext[ch] == 1'b0) : (e == ack_at)) phase = 3;
                        else if (TMO != 0 && e == start + TMO) begin
                            phase = 4; fired = 1;
                        end
                    end
                    default: if (AS_L) phase = 1;
                endcase
                if (fired) begin
                    flag = 1; chan = ch_oh;
                end else if (ClearFlag_H) begin
                    flag = 0; chan = '0;
                end
                prev_ext = ExtDtack_L;
            end
            x.edge_no = e;
            x.dtack_l = (phase != 3);
            x.berr_l  = (phase != 4);
            x.busy    = (phase >= 2);
            x.flag    = flag;
            x.chan    = chan;
            exp_q.push_back(x);
        end
    end

    // ---------------- monitor ----------------
    task automatic chk(input string name, input int edge_no, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s edge %0d: got %0h expected %0h", name, edge_no, got, want);
        end
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(negedge Clk);
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                chk("dtack", x.edge_no, 32'(DtackOut_L), 32'(x.dtack_l));
                chk("berr",  x.edge_no, 32'(BErrOut_L),  32'(x.berr_l));
                chk("busy",  x.edge_no, 32'(Busy_H),     32'(x.busy));
                chk("flag",  x.edge_no, 32'(TimeoutFlag_H), 32'(x.flag));
                chk("chan",  x.edge_no, 32'(TimeoutChan_H), 32'(x.chan));
                chk("dtack_berr_excl", x.edge_no, 32'(!DtackOut_L && !BErrOut_L), 32'(0));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic set_ws(input int ch, input int val);
        WaitStates[ch*WS_W +: WS_W] = WS_W'(val);
    endtask

    initial begin : stim
        int hold;
        tick(3);
        // Reset released with AS_L already low: must not ack that cycle
        Reset_H = 0; tick(5);
        AS_L = 1; tick(1);
        AS_L = 0; Select_H = '0; tick(3);
        AS_L = 1; tick(2);

        // Ch1 internal, three wait states
        Select_H = 4'b0010; ExtMode_H = '0; set_ws(1, 3);
        AS_L = 0; tick(8);
        AS_L = 1; tick(2);

        // Ch2 external, device acks late
        Select_H = 4'b0100; ExtMode_H = 4'b0100; ExtDtack_L = '1;
        AS_L = 0; tick(8);
        ExtDtack_L[2] = 0; tick(3);
        AS_L = 1; ExtDtack_L = '1; tick(2);

        // Ch0 external, device never acks: watchdog BERR, then clear
        Select_H = 4'b0001; ExtMode_H = 4'b0001;
        AS_L = 0; tick(TMO + 8);
        AS_L = 1; tick(2);
        ClearFlag_H = 1; tick(1);
        ClearFlag_H = 0; tick(2);

        // Two selects: lowest index wins
        Select_H = 4'b0110; ExtMode_H = '0; set_ws(1, 0); set_ws(2, 7);
        AS_L = 0; tick(4);
        AS_L = 1; tick(2);

        // External ack sampled the edge before the timeout edge
        Select_H = 4'b0001; ExtMode_H = 4'b0001; ExtDtack_L = '1;
        AS_L = 0; tick(1);
        tick(TMO - 2);
        ExtDtack_L[0] = 0; tick(3);
        AS_L = 1; ExtDtack_L = '1; tick(2);

        // Ch3 long wait aborted, then back-to-back cycle
        Select_H = 4'b1000; ExtMode_H = '0; set_ws(3, 15);
        AS_L = 0; tick(4);
        AS_L = 1; tick(1);
        set_ws(3, 2);
        AS_L = 0; tick(6);
        AS_L = 1; tick(2);

        // Randomised bus cycles
        for (int c = 0; c < 60; c++) begin
            Select_H   = NUM_CH'($urandom);
            ExtMode_H  = NUM_CH'($urandom);
            WaitStates = (NUM_CH*WS_W)'($urandom);
            ExtDtack_L = ($urandom_range(0, 3) == 0) ? NUM_CH'($urandom) : '1;
            AS_L = 0;
            hold = (c % 15 == 7) ? TMO + 4 : int'($urandom_range(1, 22));
            for (int h = 0; h < hold; h++) begin
                tick(1);
                Select_H    = NUM_CH'($urandom);
                WaitStates  = (NUM_CH*WS_W)'($urandom);
                ExtMode_H   = NUM_CH'($urandom);
                if ($urandom_range(0, 5) == 0) ExtDtack_L = NUM_CH'($urandom);
                ClearFlag_H = ($urandom_range(0, 7) == 0);
            end
            ClearFlag_H = ($urandom_range(0, 3) == 0);
            AS_L = 1;
            tick(int'($urandom_range(1, 3)));
            ClearFlag_H = 0;
            if (c % 20 == 13) begin
                Reset_H = 1; tick(2); Reset_H = 0;
            end
        end

        tick(3);
        @(negedge Clk); #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
